// File: rtl/mii_tx_framer_pkg.sv
// Shared types and constants for the MII transmit framer.
package mii_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_IFG
  } state_t;

  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;
  localparam int         DEFAULT_IFG_NIBBLES = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mii_tx_framer.sv
// Drains one frame of tx_len bytes from the byte FIFO and emits it as a
// preamble/SFD-prefixed nibble stream, followed by a forced inter-frame gap.
module mii_tx_framer
  import mii_tx_framer_pkg::*;
#(
  parameter int LEN_W            = 11,
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = DEFAULT_IFG_NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_underrun,
  output logic             fifo_rd,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic [3:0]       txd,
  output logic             tx_en,
  output state_t           dbg_state
);

  localparam int NIB_W = $clog2(max_int(PREAMBLE_NIBBLES, IFG_NIBBLES) + 1);
  localparam logic [NIB_W-1:0] PRE_LAST = NIB_W'(PREAMBLE_NIBBLES);
  localparam logic [NIB_W-1:0] PRE_READ = NIB_W'(PREAMBLE_NIBBLES - 1);
  localparam logic [NIB_W-1:0] IFG_LAST = NIB_W'(IFG_NIBBLES);

  state_t           state;
  logic [NIB_W-1:0] nib_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [3:0]       hi_nib_q;
  logic             on_high;
  logic             abort_pend;

  assign dbg_state = state;

  // Valid/ready contract: fifo_rd is a one-cycle strobe issued only while
  // fifo_empty was low; the byte is consumed from fifo_data one cycle later.
  // abort_pend records a read that was due but could not be issued; the
  // nibble in flight still completes before the frame is cut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      nib_cnt     <= '0;
      byte_cnt    <= '0;
      hi_nib_q    <= '0;
      on_high     <= 1'b0;
      abort_pend  <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      fifo_rd     <= 1'b0;
      txd         <= '0;
      tx_en       <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      fifo_rd     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start && tx_len != '0) begin
            state      <= ST_PREAMBLE;
            tx_busy    <= 1'b1;
            tx_en      <= 1'b1;
            txd        <= PREAMBLE_NIBBLE;
            byte_cnt   <= tx_len;
            nib_cnt    <= NIB_W'(1);
            abort_pend <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (nib_cnt == PRE_LAST) begin
            if (abort_pend) begin
              state       <= ST_IFG;
              tx_en       <= 1'b0;
              txd         <= '0;
              tx_underrun <= 1'b1;
              nib_cnt     <= NIB_W'(1);
              abort_pend  <= 1'b0;
            end else begin
              state <= ST_SFD;
              txd   <= SFD_NIBBLE;
            end
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
            txd     <= PREAMBLE_NIBBLE;
            if (nib_cnt == PRE_READ) begin
              fifo_rd    <= !fifo_empty;
              abort_pend <= fifo_empty;
            end
          end
        end
        ST_SFD: begin
          state    <= ST_DATA;
          on_high  <= 1'b0;
          txd      <= fifo_data[3:0];
          hi_nib_q <= fifo_data[7:4];
          if (byte_cnt > LEN_W'(1)) begin
            fifo_rd    <= !fifo_empty;
            abort_pend <= fifo_empty;
          end else begin
            abort_pend <= 1'b0;
          end
        end
        ST_DATA: begin
          if (!on_high) begin
            txd     <= hi_nib_q;
            on_high <= 1'b1;
          end else if (byte_cnt == LEN_W'(1)) begin
            state   <= ST_IFG;
            tx_en   <= 1'b0;
            txd     <= '0;
            tx_done <= 1'b1;
            nib_cnt <= NIB_W'(1);
          end else if (abort_pend) begin
            state       <= ST_IFG;
            tx_en       <= 1'b0;
            txd         <= '0;
            tx_underrun <= 1'b1;
            nib_cnt     <= NIB_W'(1);
            abort_pend  <= 1'b0;
          end else begin
            on_high  <= 1'b0;
            txd      <= fifo_data[3:0];
            hi_nib_q <= fifo_data[7:4];
            byte_cnt <= byte_cnt - LEN_W'(1);
            // Prefetch the byte after next only if it exists.
            if (byte_cnt > LEN_W'(2)) begin
              fifo_rd    <= !fifo_empty;
              abort_pend <= fifo_empty;
            end else begin
              abort_pend <= 1'b0;
            end
          end
        end
        ST_IFG: begin
          if (nib_cnt == IFG_LAST) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx_busy <= 1'b0;
          tx_en   <= 1'b0;
          txd     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: per-cycle output logs compared with
// hand-derived expectations indexed by cycle number relative to tx_start.
module tb_mii_tx_framer;
  import mii_tx_framer_pkg::*;

  localparam int LEN_W = 11;
  localparam int MAXC  = 140;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tx_start = 1'b0;
  logic [LEN_W-1:0] tx_len = '0;
  logic             tx_busy, tx_done, tx_underrun, fifo_rd, tx_en;
  logic [3:0]       txd;
  logic [7:0]       fifo_data = 8'h00;
  logic             fifo_empty;
  state_t           dbg_state;

  logic [7:0] fifo_q[$];
  // {tx_en, txd[3:0], fifo_rd, tx_done, tx_underrun, tx_busy} per cycle
  logic [8:0] l_obs[1:MAXC];

  int checks = 0;
  int errors = 0;

  mii_tx_framer dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun),
    .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .txd(txd), .tx_en(tx_en), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  assign fifo_empty = (fifo_q.size() == 0);
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
  end

  // Cycle 0 is the cycle tx_start is first sampled; log cycles 1..ncyc.
  task automatic launch(input logic [LEN_W-1:0] len, input int ncyc,
                        input int restart_cyc, input logic hold);
    @(negedge clk);
    tx_start = 1'b1;
    tx_len   = len;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      l_obs[c] = {tx_en, txd, fifo_rd, tx_done, tx_underrun, tx_busy};
      tx_start = hold || (c == restart_cyc);
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_en, txd, fifo_rd, tx_done, tx_underrun, tx_busy} !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000",
               {tx_en, txd, fifo_rd, tx_done, tx_underrun, tx_busy});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_one_byte();
    logic [8:0] exp;
    fifo_q.push_back(8'hA5);
    launch(11'd1, 45, 0, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      exp = '0;
      exp[8]   = (c <= 18);
      exp[7:4] = (c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c == 17) ? 4'h5 :
                 (c == 18) ? 4'hA : 4'h0;
      exp[3]   = (c == 15);
      exp[2]   = (c == 19);
      exp[0]   = (c <= 42);
      checks++;
      if (l_obs[c] !== exp) begin
        errors++;
        $display("FAIL one_byte c=%0d got %h exp %h", c, l_obs[c], exp);
      end
    end
  endtask

  task automatic test_four_bytes_restart();
    logic [8:0] exp;
    logic [3:0] dn[0:7];
    int n_done;
    dn = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};
    for (int b = 1; b <= 4; b++) fifo_q.push_back(8'(b));
    launch(11'd4, 52, 10, 1'b0);
    n_done = 0;
    for (int c = 1; c <= 52; c++) begin
      exp = '0;
      exp[8]   = (c <= 24);
      exp[7:4] = (c <= 15) ? 4'h5 : (c == 16) ? 4'hD :
                 (c >= 17 && c <= 24) ? dn[c-17] : 4'h0;
      exp[3]   = (c == 15) || (c == 17) || (c == 19) || (c == 21);
      exp[2]   = (c == 25);
      exp[0]   = (c <= 48);
      if (l_obs[c][2]) n_done++;
      checks++;
      if (l_obs[c] !== exp) begin
        errors++;
        $display("FAIL four_bytes c=%0d got %h exp %h", c, l_obs[c], exp);
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL four_bytes_done_count got %0d exp 1", n_done);
    end
  endtask

  // Reads due at 15,17 succeed; the read due at 19 finds the FIFO empty,
  // so byte 1 finishes at cycle 20 and the abort shows at cycle 21.
  task automatic test_data_underrun();
    logic [8:0] exp;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    launch(11'd4, 47, 0, 1'b0);
    for (int c = 1; c <= 47; c++) begin
      exp = '0;
      exp[8]   = (c <= 20);
      exp[7:4] = (c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c == 17) ? 4'h1 :
                 (c == 19) ? 4'h2 : 4'h0;
      exp[3]   = (c == 15) || (c == 17);
      exp[1]   = (c == 21);
      exp[0]   = (c <= 44);
      checks++;
      if (l_obs[c] !== exp) begin
        errors++;
        $display("FAIL data_underrun c=%0d got %h exp %h", c, l_obs[c], exp);
      end
    end
  endtask

  task automatic test_preamble_underrun();
    logic [8:0] exp;
    launch(11'd2, 42, 0, 1'b0);
    for (int c = 1; c <= 42; c++) begin
      exp = '0;
      exp[8]   = (c <= 15);
      exp[7:4] = (c <= 15) ? 4'h5 : 4'h0;
      exp[1]   = (c == 16);
      exp[0]   = (c <= 39);
      checks++;
      if (l_obs[c] !== exp) begin
        errors++;
        $display("FAIL preamble_underrun c=%0d got %h exp %h", c, l_obs[c], exp);
      end
    end
  endtask

  task automatic test_zero_len();
    fifo_q.push_back(8'h77);
    launch(11'd0, 20, 0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (l_obs[c] !== 9'h000) begin
        errors++;
        $display("FAIL zero_len c=%0d got %h exp 000", c, l_obs[c]);
      end
    end
    fifo_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [8:0] exp;
    for (int b = 1; b <= 4; b++) fifo_q.push_back(8'(b));
    launch(11'd4, 19, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_en, txd, fifo_rd, tx_done, tx_underrun, tx_busy} !== 9'h000) begin
      errors++;
      $display("FAIL midframe_reset_outputs got %h exp 000",
               {tx_en, txd, fifo_rd, tx_done, tx_underrun, tx_busy});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midframe_reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    fifo_q.delete();
    fifo_q.push_back(8'h5A);
    launch(11'd1, 20, 0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      exp = '0;
      exp[8]   = (c <= 18);
      exp[7:4] = (c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c == 17) ? 4'hA :
                 (c == 18) ? 4'h5 : 4'h0;
      exp[3]   = (c == 15);
      exp[2]   = (c == 19);
      exp[0]   = 1'b1;
      checks++;
      if (l_obs[c] !== exp) begin
        errors++;
        $display("FAIL after_reset c=%0d got %h exp %h", c, l_obs[c], exp);
      end
    end
    repeat (30) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[0:2];
    int hi_runs[$];
    int lo_runs[$];
    int run;
    logic cur;
    bytes = '{8'h3C, 8'h96, 8'hE1};
    for (int i = 0; i < 3; i++) fifo_q.push_back(bytes[i]);
    launch(11'd1, 106, 0, 1'b1);
    cur = l_obs[1][8];
    run = 1;
    for (int c = 2; c <= 106; c++) begin
      if (l_obs[c][8] === cur) begin
        run++;
      end else begin
        if (cur) hi_runs.push_back(run);
        else lo_runs.push_back(run);
        cur = l_obs[c][8];
        run = 1;
      end
    end
    checks++;
    if (hi_runs.size() !== 3 || lo_runs.size() !== 2) begin
      errors++;
      $display("FAIL b2b_burst_count got %0d/%0d exp 3/2", hi_runs.size(), lo_runs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hi_runs[i] !== 18) begin
          errors++;
          $display("FAIL b2b_burst_len i=%0d got %0d exp 18", i, hi_runs[i]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (lo_runs[i] !== 25) begin
          errors++;
          $display("FAIL b2b_gap_len i=%0d got %0d exp 25", i, lo_runs[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({l_obs[17 + 43*i][7:4], l_obs[18 + 43*i][7:4]} !== {bytes[i][3:0], bytes[i][7:4]}) begin
        errors++;
        $display("FAIL b2b_data i=%0d got %h%h exp %h%h", i, l_obs[17 + 43*i][7:4],
                 l_obs[18 + 43*i][7:4], bytes[i][3:0], bytes[i][7:4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_four_bytes_restart();
    test_data_underrun();
    test_preamble_underrun();
    test_zero_len();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
